// File: rtl/data_wrap.sv
// Y86-64 data-memory stage: byte-addressed little-endian memory, combinational
// reads, clocked 8-byte writes, and stat generation. Optional macro
// DATAWRAP_DMEM_ERR_PORT_EN exposes the internal address-error flag as dmem_err.
module data_wrap #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic [3:0]  icode,
  input  logic        Instr_valid,
  input  logic        imem_error,
  output logic [63:0] valM,
  output logic [1:0]  stat
`ifdef DATAWRAP_DMEM_ERR_PORT_EN
  ,
  output logic        dmem_err
`endif
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'b00;
  localparam logic [1:0] S_HLT = 2'b01;
  localparam logic [1:0] S_ADR = 2'b10;
  localparam logic [1:0] S_INS = 2'b11;

  // Memory is deliberately never reset so its contents survive rst pulses;
  // it relies on the zero power-up contents of the target RAM.
  logic [7:0] mem [MEM_BYTES];

  logic          rd_op;
  logic          wr_op;
  logic [63:0]   acc_addr;
  logic [63:0]   wr_data;
  logic          dmem_error;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic [63:0]   rd_word;

  always_comb begin
    rd_op    = 1'b0;
    wr_op    = 1'b0;
    acc_addr = valE;
    wr_data  = valA;
    case (icode)
      I_RMMOVQ: wr_op = 1'b1;
      I_MRMOVQ: rd_op = 1'b1;
      I_CALL: begin
        wr_op   = 1'b1;
        wr_data = valP;
      end
      I_RET, I_POPQ: begin
        rd_op    = 1'b1;
        acc_addr = valA;
      end
      I_PUSHQ:  wr_op = 1'b1;
      default:  ;
    endcase
  end

  // 65-bit sum keeps addresses near 2^64 from wrapping into range.
  always_comb begin
    dmem_error = (rd_op || wr_op) &&
                 (({1'b0, acc_addr} + 65'd7) >= 65'(MEM_BYTES));
    wr_en = rst && wr_op && !dmem_error && Instr_valid && !imem_error;
    idx   = acc_addr[AW-1:0];
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[idx + AW'(i)];
    end
    valM = (rst && rd_op && !dmem_error) ? rd_word : '0;
  end

  // All 8 bytes commit on the same edge; a same-cycle read sees pre-edge data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    if (!rst)                            stat = S_AOK;
    else if (imem_error || dmem_error)   stat = S_ADR;
    else if (!Instr_valid)               stat = S_INS;
    else if (icode == I_HALT)            stat = S_HLT;
    else                                 stat = S_AOK;
  end

`ifdef DATAWRAP_DMEM_ERR_PORT_EN
  assign dmem_err = rst && dmem_error;
`endif

endmodule

// File: tb/tb_data_wrap.sv
// Directed bench for data_wrap: driver pushes expected {err, stat, valM} into a
// queue each step; a negedge monitor pops and compares against the DUT.
module tb_data_wrap;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] valE, valA, valP;
  logic [3:0]  icode;
  logic        Instr_valid, imem_error;
  logic [63:0] valM;
  logic [1:0]  stat;
`ifdef DATAWRAP_DMEM_ERR_PORT_EN
  logic        dmem_err;
`endif

  data_wrap #(.MEM_BYTES(65536)) dut (
    .clk         (clk),
    .rst         (rst),
    .valE        (valE),
    .valA        (valA),
    .valP        (valP),
    .icode       (icode),
    .Instr_valid (Instr_valid),
    .imem_error  (imem_error),
    .valM        (valM),
    .stat        (stat)
`ifdef DATAWRAP_DMEM_ERR_PORT_EN
    ,
    .dmem_err    (dmem_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {err, stat, valM}
  logic [66:0] exp_q[$];
  string       name_q[$];
  logic        chk_pending = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (chk_pending) begin
      logic [66:0] e;
      string       nm;
      logic        bad;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: no expected entry for DUT output");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        bad = (valM !== e[63:0]) || (stat !== e[65:64]);
`ifdef DATAWRAP_DMEM_ERR_PORT_EN
        bad = bad || (dmem_err !== e[66]);
        if (bad) $display("FAIL %s: got valM=%h stat=%b err=%b, expected valM=%h stat=%b err=%b",
                          nm, valM, stat, dmem_err, e[63:0], e[65:64], e[66]);
`else
        if (bad) $display("FAIL %s: got valM=%h stat=%b, expected valM=%h stat=%b",
                          nm, valM, stat, e[63:0], e[65:64]);
`endif
        if (bad) errors++;
      end
    end
  end

  // driver: apply one instruction for one cycle and queue its expected outputs
  task automatic step(input logic r, input logic [3:0] ic, input logic [63:0] e,
                      input logic [63:0] a, input logic [63:0] p, input logic iv,
                      input logic ie, input logic [63:0] x_valM,
                      input logic [1:0] x_stat, input logic x_err, input string nm);
    @(posedge clk);
    #1;
    rst = r; icode = ic; valE = e; valA = a; valP = p;
    Instr_valid = iv; imem_error = ie;
    exp_q.push_back({x_err, x_stat, x_valM});
    name_q.push_back(nm);
    chk_pending = 1'b1;
  endtask

  initial begin
    rst = 1'b0; icode = 4'h1; valE = '0; valA = '0; valP = '0;
    Instr_valid = 1'b1; imem_error = 1'b0;

    // reset state, read of an error address still reports nothing
    step(0, 4'h5, 64'd58,    0, 0, 1, 0, 64'd0, 2'b00, 0, "reset_read");
    step(0, 4'h5, 64'd65529, 0, 0, 1, 0, 64'd0, 2'b00, 0, "reset_err_masked");

    // store / load
    step(1, 4'h4, 64'd58, 64'd12, 0, 1, 0, 64'd0,  2'b00, 0, "rmmovq");
    step(1, 4'h5, 64'd58, 0,      0, 1, 0, 64'd12, 2'b00, 0, "mrmovq_58");
    step(1, 4'h5, 64'd57, 0,      0, 1, 0, 64'h0C00, 2'b00, 0, "mrmovq_57_le");

    // little-endian, misaligned word
    step(1, 4'h4, 64'd200, 64'h0102030405060708, 0, 1, 0, 64'd0, 2'b00, 0, "rmmovq_200");
    step(1, 4'h5, 64'd201, 0, 0, 1, 0, 64'h0001020304050607, 2'b00, 0, "mrmovq_201");

    // call / ret / popq
    step(1, 4'h8, 64'd100, 64'd999, 64'd11, 1, 0, 64'd0,  2'b00, 0, "call");
    step(1, 4'h9, 64'd0,   64'd100, 0,      1, 0, 64'd11, 2'b00, 0, "ret");
    step(1, 4'hB, 64'd0,   64'd100, 0,      1, 0, 64'd11, 2'b00, 0, "popq");

    // address boundary
    step(1, 4'hA, 64'd65528, 64'h1122334455667788, 0, 1, 0, 64'd0, 2'b00, 0, "pushq_top");
    step(1, 4'h5, 64'd65528, 0, 0, 1, 0, 64'h1122334455667788, 2'b00, 0, "read_top");
    step(1, 4'h5, 64'd65529, 0, 0, 1, 0, 64'd0, 2'b10, 1, "read_oob");
    step(1, 4'h4, 64'd65529, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0, 64'd0, 2'b10, 1, "write_oob");
    step(1, 4'h5, 64'd65528, 0, 0, 1, 0, 64'h1122334455667788, 2'b00, 0, "top_unchanged");
    step(1, 4'h5, 64'hFFFFFFFFFFFFFFFC, 0, 0, 1, 0, 64'd0, 2'b10, 1, "read_wrap");
    step(1, 4'h9, 64'd0, 64'd65530, 0, 1, 0, 64'd0, 2'b10, 1, "ret_oob");

    // status priority and suppressed writes
    step(1, 4'h1, 0, 0, 0, 0, 0, 64'd0, 2'b11, 0, "ins");
    step(1, 4'h0, 0, 0, 0, 1, 0, 64'd0, 2'b01, 0, "hlt");
    step(1, 4'h1, 0, 0, 0, 0, 1, 64'd0, 2'b10, 0, "imem_over_ins");
    step(1, 4'h0, 0, 0, 0, 1, 1, 64'd0, 2'b10, 0, "imem_over_hlt");
    step(1, 4'h4, 64'd300, 64'd99, 0, 0, 0, 64'd0, 2'b11, 0, "write_invalid");
    step(1, 4'h5, 64'd300, 0, 0, 1, 0, 64'd0, 2'b00, 0, "no_write_invalid");
    step(1, 4'h4, 64'd308, 64'd5, 0, 1, 1, 64'd0, 2'b10, 0, "write_imem_err");
    step(1, 4'h5, 64'd308, 0, 0, 1, 0, 64'd0, 2'b00, 0, "no_write_imem_err");

    // reset blocks writes, keeps memory
    step(0, 4'h4, 64'd64, 64'd7, 0, 1, 0, 64'd0, 2'b00, 0, "reset_write_a");
    step(0, 4'h4, 64'd64, 64'd7, 0, 1, 0, 64'd0, 2'b00, 0, "reset_write_b");
    step(1, 4'h5, 64'd64, 0, 0, 1, 0, 64'd0,  2'b00, 0, "after_reset_64");
    step(1, 4'h5, 64'd58, 0, 0, 1, 0, 64'd12, 2'b00, 0, "after_reset_58");
    step(1, 4'h9, 64'd0, 64'd100, 0, 1, 0, 64'd11, 2'b00, 0, "after_reset_100");

    @(posedge clk);
    #1;
    chk_pending = 1'b0;
    icode = 4'h1;
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
